spart_rx_fifo: RTL

Parametrised SPART receive channel: a 16x-oversampled asynchronous serial receiver with configurable data width, optional parity, per-word error flags and a show-ahead receive FIFO. It sits between the `rxd` pin and the driver-facing bus logic and replaces the single-byte receive buffer. The bus side can read back-to-back words without dropping data, and can detect parity, framing and overrun errors.

---
 rtl/spart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spart_rx_fifo.sv
// SPART receive channel: 16x-oversampled serial receiver with optional parity,
// per-word error flags and a show-ahead receive FIFO with sticky overrun.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              divisor,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clr_ovr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic [1:0]                    rd_err,
    output logic                          rda,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    logic [1:0]           sync_q;
    logic                 rxs_s;
    logic [DIV_W-1:0]     tcnt_q;
    logic [DIV_W-1:0]     tcnt_d;
    logic [DIV_W-1:0]     div_eff_s;
    logic                 tick_s;
    logic                 mid_s;
    logic                 smp_s;
    rx_state_t            state_q;
    logic [3:0]           scnt_q;
    logic [3:0]           bcnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q;
    logic                 push_s;
    logic [WW-1:0]        push_word_s;
    logic [WW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q;
    logic [PW-1:0]        rptr_q;
    logic [CW-1:0]        count_q;
    logic                 ovr_q;
    logic                 full_s;
    logic                 empty_s;
    logic                 pop_s;
    logic                 wr_s;
    logic                 drop_s;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxs_s     = sync_q[1];
    assign div_eff_s = (divisor == '0) ? DIV_W'(1) : divisor;
    // >= keeps the counter bounded if the divisor shrinks while running
    assign tick_s    = (tcnt_q >= (div_eff_s - DIV_W'(1)));
    assign tcnt_d    = tick_s ? '0 : (tcnt_q + DIV_W'(1));
    assign mid_s     = tick_s && (scnt_q == 4'd6);
    assign smp_s     = tick_s && (scnt_q == 4'd14);

    // Free-running 16x sample tick, deliberately not aligned to frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    // Receive state machine: start validation, data shift, parity and stop sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scnt_q  <= 4'd0;
            bcnt_q  <= 4'd0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs_s) begin
                        scnt_q  <= 4'd0;
                        state_q <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    if (mid_s) begin
                        if (rxs_s) begin
                            state_q <= IDLE;
                        end else begin
                            scnt_q  <= 4'd0;
                            bcnt_q  <= 4'd0;
                            perr_q  <= 1'b0;
                            state_q <= DATA;
                        end
                    end else if (tick_s) begin
                        scnt_q <= scnt_q + 4'd1;
                    end else begin
                        scnt_q <= scnt_q;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        scnt_q <= scnt_q + 4'd1;
                    end else begin
                        scnt_q <= scnt_q;
                    end
                    if (smp_s) begin
                        shreg_q <= {rxs_s, shreg_q[DATA_BITS-1:1]};
                        bcnt_q  <= bcnt_q + 4'd1;
                        if (bcnt_q == 4'(DATA_BITS - 1)) begin
                            state_q <= parity_en ? PARITY : STOP;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        state_q <= DATA;
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        scnt_q <= scnt_q + 4'd1;
                    end else begin
                        scnt_q <= scnt_q;
                    end
                    if (smp_s) begin
                        perr_q  <= (^shreg_q) ^ rxs_s ^ parity_odd;
                        state_q <= STOP;
                    end else begin
                        state_q <= PARITY;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        scnt_q <= scnt_q + 4'd1;
                    end else begin
                        scnt_q <= scnt_q;
                    end
                    if (smp_s) begin
                        state_q <= rxs_s ? IDLE : WAIT_HIGH;
                    end else begin
                        state_q <= STOP;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not retrigger reception
                    if (rxs_s) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_HIGH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign push_s      = (state_q == STOP) && smp_s;
    assign push_word_s = {perr_q, ~rxs_s, shreg_q};

    assign full_s  = (count_q == CW'(FIFO_DEPTH));
    assign empty_s = (count_q == '0);
    assign pop_s   = rd_en && !empty_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign wr_s    = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && !wr_s;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_s) begin
                wptr_q <= wptr_q + PW'(1);
            end else begin
                wptr_q <= wptr_q;
            end
            if (pop_s) begin
                rptr_q <= rptr_q + PW'(1);
            end else begin
                rptr_q <= rptr_q;
            end
            case ({wr_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage, cleared on reset so the empty head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_s) begin
            mem_q[wptr_q] <= push_word_s;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (drop_s) begin
            ovr_q <= 1'b1;
        end else if (clr_ovr) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_q;
        end
    end

    assign rd_data = mem_q[rptr_q][DATA_BITS-1:0];
    assign rd_err  = mem_q[rptr_q][WW-1:DATA_BITS];
    assign rda     = !empty_s;
    assign count   = count_q;
    assign overrun = ovr_q;

endmodule
